// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the BRAM parameter loaders.
//   - State encoding codes and the loader state type.
//   - Default BRAM geometry (data width, address width).
//   - Base addresses of the weight and bias regions in the parameter BRAM.
// No ports: this is a package imported by the loader, its interface and benches.
// ---------------------------------------------------------------------------
package loader_pkg;

    // Default geometry of the shared parameter BRAM
    localparam int DATA_W = 8;
    localparam int ADDR_W = 15;

    // Region layout inside the parameter BRAM
    localparam logic [ADDR_W-1:0] WEIGHT_BASE_ADDR = 15'd0;
    localparam logic [ADDR_W-1:0] BIAS_BASE_ADDR   = 15'd16384;

    // State encoding
    localparam logic [1:0] IDLE_CODE  = 2'd0;
    localparam logic [1:0] ISSUE_CODE = 2'd1;
    localparam logic [1:0] DRAIN_CODE = 2'd2;
    localparam logic [1:0] DONE_CODE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE_CODE,
        ST_ISSUE = ISSUE_CODE,
        ST_DRAIN = DRAIN_CODE,
        ST_DONE  = DONE_CODE
    } state_t;

endpackage

// File: rtl/bram_param_loader_if.sv
// ---------------------------------------------------------------------------
// bram_param_loader_if
// Read-only BRAM port driven by a parameter loader.
//   bram_en   : BRAM enable          (loader -> BRAM)
//   bram_ren  : BRAM read enable     (loader -> BRAM)
//   bram_addr : BRAM address         (loader -> BRAM)
//   bram_dout : BRAM read data       (BRAM -> loader)
// Modports: master = loader side, slave = BRAM / arbiter side.
// ---------------------------------------------------------------------------
interface bram_param_loader_if #(
    parameter int W          = loader_pkg::DATA_W,
    parameter int ADDR_WIDTH = loader_pkg::ADDR_W
);
    logic                  bram_en;
    logic                  bram_ren;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [W-1:0]          bram_dout;

    modport master (
        output bram_en,
        output bram_ren,
        output bram_addr,
        input  bram_dout
    );

    modport slave (
        input  bram_en,
        input  bram_ren,
        input  bram_addr,
        output bram_dout
    );
endinterface

// File: rtl/rd_valid_pipe.sv
// ---------------------------------------------------------------------------
// rd_valid_pipe
// Delays each read-enable pulse by READ_LATENCY cycles so that the strobe
// lines up with the cycle in which the BRAM presents the matching data.
//   clk    : system clock
//   rst    : synchronous active-high reset (drops every in-flight pulse)
//   ren    : read enable as issued to the BRAM
//   strobe : capture strobe, ren delayed by READ_LATENCY cycles
// ---------------------------------------------------------------------------
module rd_valid_pipe #(
    parameter int READ_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ren,
    output logic strobe
);

    logic [READ_LATENCY-1:0] shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
        end else begin
            shift[0] <= ren;
            for (int i = 1; i < READ_LATENCY; i++) begin
                shift[i] <= shift[i-1];
            end
        end
    end

    assign strobe = shift[READ_LATENCY-1];

endmodule

// File: rtl/bram_param_loader.sv
// ---------------------------------------------------------------------------
// bram_param_loader
// Bursts COUNT consecutive W-bit words out of a read-only BRAM starting at a
// run-time base address and packs them into one flat register.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   start      : single-cycle load request, honoured only in IDLE or DONE
//   base_addr  : first BRAM address, latched on an accepted start
//   bram       : BRAM read port (master side)
//   data_out   : packed words, word i at [i*W +: W]
//   busy       : high while issuing or draining reads
//   done       : level, high from load completion until next start or rst
// ---------------------------------------------------------------------------
module bram_param_loader
    import loader_pkg::*;
#(
    parameter int W              = DATA_W,
    parameter int COUNT          = 8,
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_START = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    bram_param_loader_if.master    bram,
    output logic [COUNT*W-1:0]     data_out,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  en_q;
    logic                  ren_q;
    logic                  busy_q;
    logic                  done_q;
    logic [CW-1:0]         issue_cnt;
    logic [CW-1:0]         write_ptr;
    logic [COUNT*W-1:0]    data_q;
    logic                  cap_strobe;

    // Validity comes only from the delayed read enables, never from counters,
    // so a reset mid-burst cleanly discards data still in the BRAM pipeline.
    rd_valid_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_valid (
        .clk    (clk),
        .rst    (rst),
        .ren    (ren_q),
        .strobe (cap_strobe)
    );

    // Control FSM and capture datapath. Every output is a register; start only
    // affects outputs from the following cycle onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            en_q      <= 1'b0;
            ren_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            issue_cnt <= '0;
            write_ptr <= '0;
            data_q    <= '0;
        end else begin
            // Captures can land in ISSUE as well as DRAIN when the latency is
            // shorter than the burst.
            if (cap_strobe) begin
                data_q[int'(write_ptr)*W +: W] <= bram.bram_dout;
                write_ptr <= write_ptr + CW'(1);
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        addr_q    <= base_addr;
                        issue_cnt <= '0;
                        write_ptr <= '0;
                        if (CLEAR_ON_START != 0) begin
                            data_q <= '0;
                        end
                        en_q   <= 1'b1;
                        ren_q  <= 1'b1;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        state  <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    issue_cnt <= issue_cnt + CW'(1);
                    if (issue_cnt == LAST) begin
                        ren_q <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        // Address wraps modulo 2^ADDR_WIDTH by construction.
                        addr_q <= base_q + ADDR_WIDTH'(issue_cnt + CW'(1));
                    end
                end

                ST_DRAIN: begin
                    if (cap_strobe && write_ptr == LAST) begin
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bram.bram_en   = en_q;
    assign bram.bram_ren  = ren_q;
    assign bram.bram_addr = addr_q;
    assign data_out       = data_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_bram_param_loader.sv
// ---------------------------------------------------------------------------
// tb_bram_param_loader
// Directed bench for bram_param_loader. Five loader instances cover the
// configurations of interest, each fed by its own BRAM model with the
// matching read latency:
//   a: COUNT=8 RL=2 clear=0   b: COUNT=8 RL=1   c: COUNT=8 RL=3
//   d: COUNT=4 RL=2           e: COUNT=8 RL=2 clear=1
// BRAM contents: upper half (a[14]=1) holds 0x10+a[7:0], lower half 0xA0+a[7:0].
// ---------------------------------------------------------------------------
module tb_bram_param_loader;
    import loader_pkg::*;

    logic        clk = 1'b0;
    logic [4:0]  rst;
    logic [4:0]  start;
    logic [14:0] base [5];
    logic [63:0] data_a, data_b, data_c, data_e;
    logic [31:0] data_d;
    logic [4:0]  busy_v;
    logic [4:0]  done_v;

    int vectors     = 0;
    int miscompares = 0;
    int ren_cnt_a   = 0;
    int snap;
    int cyc;
    logic [14:0] addr_log_d [$];

    always #5 clk = ~clk;

    bram_param_loader_if #(.W(8), .ADDR_WIDTH(15)) if_a ();
    bram_param_loader_if #(.W(8), .ADDR_WIDTH(15)) if_b ();
    bram_param_loader_if #(.W(8), .ADDR_WIDTH(15)) if_c ();
    bram_param_loader_if #(.W(8), .ADDR_WIDTH(15)) if_d ();
    bram_param_loader_if #(.W(8), .ADDR_WIDTH(15)) if_e ();

    bram_param_loader #(.W(8), .COUNT(8), .ADDR_WIDTH(15), .READ_LATENCY(2), .CLEAR_ON_START(0)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .base_addr(base[0]), .bram(if_a),
        .data_out(data_a), .busy(busy_v[0]), .done(done_v[0]));
    bram_param_loader #(.W(8), .COUNT(8), .ADDR_WIDTH(15), .READ_LATENCY(1), .CLEAR_ON_START(0)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .base_addr(base[1]), .bram(if_b),
        .data_out(data_b), .busy(busy_v[1]), .done(done_v[1]));
    bram_param_loader #(.W(8), .COUNT(8), .ADDR_WIDTH(15), .READ_LATENCY(3), .CLEAR_ON_START(0)) dut_c (
        .clk(clk), .rst(rst[2]), .start(start[2]), .base_addr(base[2]), .bram(if_c),
        .data_out(data_c), .busy(busy_v[2]), .done(done_v[2]));
    bram_param_loader #(.W(8), .COUNT(4), .ADDR_WIDTH(15), .READ_LATENCY(2), .CLEAR_ON_START(0)) dut_d (
        .clk(clk), .rst(rst[3]), .start(start[3]), .base_addr(base[3]), .bram(if_d),
        .data_out(data_d), .busy(busy_v[3]), .done(done_v[3]));
    bram_param_loader #(.W(8), .COUNT(8), .ADDR_WIDTH(15), .READ_LATENCY(2), .CLEAR_ON_START(1)) dut_e (
        .clk(clk), .rst(rst[4]), .start(start[4]), .base_addr(base[4]), .bram(if_e),
        .data_out(data_e), .busy(busy_v[4]), .done(done_v[4]));

    function automatic logic [7:0] mem(input logic [14:0] a);
        return a[14] ? 8'h10 + a[7:0] : 8'hA0 + a[7:0];
    endfunction

    // BRAM models: data for an address read in cycle c is on dout in cycle c+RL;
    // non-read cycles push a 0xEE marker so mistimed captures show up.
    logic [7:0] pa [2];
    logic [7:0] pb [1];
    logic [7:0] pc [3];
    logic [7:0] pd [2];
    logic [7:0] pe [2];

    always @(posedge clk) begin
        pa[0] <= (if_a.bram_en && if_a.bram_ren) ? mem(if_a.bram_addr) : 8'hEE;
        pa[1] <= pa[0];
        pb[0] <= (if_b.bram_en && if_b.bram_ren) ? mem(if_b.bram_addr) : 8'hEE;
        pc[0] <= (if_c.bram_en && if_c.bram_ren) ? mem(if_c.bram_addr) : 8'hEE;
        pc[1] <= pc[0];
        pc[2] <= pc[1];
        pd[0] <= (if_d.bram_en && if_d.bram_ren) ? mem(if_d.bram_addr) : 8'hEE;
        pd[1] <= pd[0];
        pe[0] <= (if_e.bram_en && if_e.bram_ren) ? mem(if_e.bram_addr) : 8'hEE;
        pe[1] <= pe[0];
    end

    assign if_a.bram_dout = pa[1];
    assign if_b.bram_dout = pb[0];
    assign if_c.bram_dout = pc[2];
    assign if_d.bram_dout = pd[1];
    assign if_e.bram_dout = pe[1];

    // Read-enable monitors sampled mid-cycle
    always @(negedge clk) begin
        if (if_a.bram_ren === 1'b1) ren_cnt_a++;
        if (if_d.bram_ren === 1'b1) addr_log_d.push_back(if_d.bram_addr);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pulses start for one edge (edge k); returns at the negedge of cycle k+1.
    task automatic applyStimulus(input int idx, input logic [14:0] b);
        @(negedge clk);
        start[idx] = 1'b1;
        base[idx]  = b;
        @(posedge clk);
        @(negedge clk);
        start[idx] = 1'b0;
    endtask

    // Counts cycles after the start edge until done is seen, bounded.
    task automatic waitDone(input int idx, input int from, output int n);
        n = from;
        while (done_v[idx] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst   = '1;
        start = '0;
        for (int i = 0; i < 5; i++) base[i] = '0;
        repeat (3) @(negedge clk);
        rst = '0;

        // Reset state
        checkOutput("rst_data",  data_a, 64'h0);
        checkOutput("rst_done",  {63'h0, done_v[0]}, 64'h0);
        checkOutput("rst_busy",  {63'h0, busy_v[0]}, 64'h0);
        checkOutput("rst_en",    {63'h0, if_a.bram_en}, 64'h0);
        checkOutput("rst_addr",  {49'h0, if_a.bram_addr}, 64'h0);

        // Basic load, RL=2
        snap = ren_cnt_a;
        applyStimulus(0, BIAS_BASE_ADDR);
        checkOutput("a_busy_k1", {63'h0, busy_v[0]}, 64'h1);
        checkOutput("a_ren_k1",  {63'h0, if_a.bram_ren}, 64'h1);
        checkOutput("a_addr_k1", {49'h0, if_a.bram_addr}, 64'd16384);
        waitDone(0, 1, cyc);
        checkOutput("a_done_lat", cyc, 11);
        checkOutput("a_ren_cnt",  ren_cnt_a - snap, 8);
        checkOutput("a_data",     data_a, 64'h1716151413121110);
        checkOutput("a_busy_end", {63'h0, busy_v[0]}, 64'h0);
        checkOutput("a_en_end",   {63'h0, if_a.bram_en}, 64'h0);

        // Read latency 1 and 3
        applyStimulus(1, BIAS_BASE_ADDR);
        waitDone(1, 1, cyc);
        checkOutput("b_done_lat", cyc, 10);
        checkOutput("b_data",     data_b, 64'h1716151413121110);
        applyStimulus(2, BIAS_BASE_ADDR);
        waitDone(2, 1, cyc);
        checkOutput("c_done_lat", cyc, 12);
        checkOutput("c_data",     data_c, 64'h1716151413121110);

        // start during ISSUE (cycle 3) and DRAIN (cycle 9) must be ignored
        snap = ren_cnt_a;
        applyStimulus(0, BIAS_BASE_ADDR);
        cyc = 1;
        while (done_v[0] !== 1'b1 && cyc < 100) begin
            start[0] = (cyc == 3 || cyc == 9);
            base[0]  = 15'd0;
            @(negedge clk);
            cyc++;
        end
        start[0] = 1'b0;
        checkOutput("ign_done_lat", cyc, 11);
        checkOutput("ign_ren_cnt",  ren_cnt_a - snap, 8);
        checkOutput("ign_data",     data_a, 64'h1716151413121110);

        // Reset four cycles into a burst
        applyStimulus(0, BIAS_BASE_ADDR);
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        checkOutput("mid_rst_data", data_a, 64'h0);
        checkOutput("mid_rst_done", {63'h0, done_v[0]}, 64'h0);
        checkOutput("mid_rst_en",   {63'h0, if_a.bram_en}, 64'h0);
        checkOutput("mid_rst_busy", {63'h0, busy_v[0]}, 64'h0);
        repeat (3) @(negedge clk);
        checkOutput("late_data",    data_a, 64'h0);
        applyStimulus(0, WEIGHT_BASE_ADDR);
        waitDone(0, 1, cyc);
        checkOutput("post_rst_lat",  cyc, 11);
        checkOutput("post_rst_data", data_a, 64'hA7A6A5A4A3A2A1A0);

        // Reload from DONE without clearing: words replaced one by one
        applyStimulus(0, BIAS_BASE_ADDR);
        checkOutput("reload_done_drop", {63'h0, done_v[0]}, 64'h0);
        checkOutput("reload_keep_k1",   data_a, 64'hA7A6A5A4A3A2A1A0);
        repeat (2) @(negedge clk);
        checkOutput("reload_keep_k3",   data_a, 64'hA7A6A5A4A3A2A1A0);
        @(negedge clk);
        checkOutput("reload_word0_k4",  data_a, 64'hA7A6A5A4A3A2A110);
        waitDone(0, 4, cyc);
        checkOutput("reload_lat",  cyc, 11);
        checkOutput("reload_data", data_a, 64'h1716151413121110);

        // Address wrap with COUNT=4
        applyStimulus(3, 15'd32766);
        waitDone(3, 1, cyc);
        checkOutput("d_done_lat", cyc, 7);
        checkOutput("d_addr_n",   addr_log_d.size(), 4);
        checkOutput("d_addr0",    {49'h0, addr_log_d[0]}, 64'd32766);
        checkOutput("d_addr1",    {49'h0, addr_log_d[1]}, 64'd32767);
        checkOutput("d_addr2",    {49'h0, addr_log_d[2]}, 64'd0);
        checkOutput("d_addr3",    {49'h0, addr_log_d[3]}, 64'd1);
        checkOutput("d_data",     {32'h0, data_d}, 64'hA1A00F0E);

        // Clear-on-start variant
        applyStimulus(4, BIAS_BASE_ADDR);
        waitDone(4, 1, cyc);
        checkOutput("e_first_data", data_e, 64'h1716151413121110);
        applyStimulus(4, WEIGHT_BASE_ADDR);
        checkOutput("e_clear_k1",   data_e, 64'h0);
        checkOutput("e_done_drop",  {63'h0, done_v[4]}, 64'h0);
        waitDone(4, 1, cyc);
        checkOutput("e_done_lat",   cyc, 11);
        checkOutput("e_data",       data_e, 64'hA7A6A5A4A3A2A1A0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
